compare_seq: RTL and testbench
==============================

# compare_seq

Multi-cycle sequencer that executes the compare instruction class (LT, GT, EQ, GTE, LTE, NE) of the Harvard Architecture Processor. It accepts one decoded instruction per handshake, reads both source operands from the register file, evaluates the comparison, and writes a 0/1 result back to the destination register. It sits between the decode stage and the register file, and owns the register-file ports while a compare is in flight.

## Interface
- DATA_W, 3: register data width; operands are unsigned
- ADDR_W, 3: register address width (8 registers)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  decode presents an instruction
- instr_ready  out  1  sequencer can accept; high only in IDLE
- opcode  in  5  instruction opcode
- rs1_addr, rs2_addr  in  ADDR_W each  source register addresses
- rd_addr  in  ADDR_W  destination register address
- rf_ra1, rf_ra2  out  ADDR_W each  register-file read addresses
- rf_rd1, rf_rd2  in  DATA_W each  read data, valid one cycle after the address
- rf_we  out  1  register-file write enable
- rf_wa  out  ADDR_W  write address
- rf_wd  out  DATA_W  write data
- flag  out  1  result of the last completed compare
- done  out  1  one-cycle pulse when a compare writes back
- illegal  out  1  one-cycle pulse when the accepted opcode is not a compare

## Operation
- Opcodes: LT=01011, GT=01100, EQ=01101, GTE=01110, LTE=01111, NE=10000. All other opcodes are illegal for this block.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - When instr_valid & instr_ready, latch opcode, rs1, rs2 and rd.
  - Legal opcode: go to READ.
  - Illegal opcode: stay in IDLE and pulse illegal on the next cycle. No register-file activity occurs.
- READ: drive rf_ra1/rf_ra2 from the latched rs1/rs2, then go to EXEC.
- EXEC: sample rf_rd1/rf_rd2, evaluate the comparison as an unsigned compare, register the 1-bit result, then go to WRITE.
- WRITE:
  - rf_we=1, rf_wa=latched rd, rf_wd=result zero-extended to DATA_W.
  - flag updates to the result; done=1.
  - Go to IDLE.
- rf_ra1/rf_ra2 hold their last value outside READ. rf_we is 0 in every state except WRITE.
- rd may equal rs1 or rs2. The operands are already captured in EXEC, so the write in WRITE never affects the current compare.

## Timing
- Reset values: state=IDLE, instr_ready=1, rf_we=0, rf_wa=0, rf_wd=0, rf_ra1=rf_ra2=0, flag=0, done=0, illegal=0.
- Cycle numbering starts at accept (cycle 0):
  - READ on cycle 1.
  - EXEC on cycle 2 (data arrives from the cycle-1 address).
  - WRITE/done on cycle 3.
  - instr_ready high again on cycle 4.
- Latency from accept to write is 3 cycles; throughput is one compare per 4 cycles.
- Illegal opcode: accept on cycle 0, illegal pulse on cycle 1, instr_ready stays 1, and the next accept is possible on cycle 1.
- instr_valid while instr_ready=0 is ignored. Decode must hold the instruction until it is accepted.
- Reset asserted mid-operation: the next cycle is IDLE with reset values. A pending write is dropped, and flag clears.
- Reset has priority over an accept in the same cycle.

## Structure
- Shared package hap_pkg holds:
  - the opcode localparams (the six compare codes);
  - the FSM state enum;
  - the helper function is_cmp_op(opcode).
- Sub-module cmp_eval: purely combinational. Inputs are opcode, a, b; output is the 1-bit result, with result 0 for non-compare opcodes. compare_seq instantiates it once, in the EXEC datapath.
- Everything else (FSM, latches, output registers) lives in compare_seq.

## Test plan
- Reset then idle: hold rst for 2 cycles -> all outputs at reset values; instr_ready=1.
- LT taken: r2=3, r5=6; LT rs1=2, rs2=5, rd=7 -> cycle 1 ra1=2, ra2=5; cycle 3 rf_we=1, wa=7, wd=001, flag=1, done=1; cycle 4 ready=1.
- All six opcodes with operands (4,4), (7,0) and (0,7) -> the written values match unsigned semantics (e.g. GTE 4,4 ->1; NE 4,4 ->0; GT 7,0 ->1; LTE 7,0 ->0).
- Illegal opcode 00000 accepted -> illegal=1 on cycle 1, no rf_we, flag unchanged; a back-to-back EQ is accepted on cycle 1.
- Overlap: rd=rs1=3, r3=5, GT r3 vs r1=2 -> wd=001 written to r3. A following EQ r3 vs r1 (r1=1) reads 1 and writes 001.
- Reset mid-operation: assert rst in EXEC -> no rf_we ever, flag=0, ready=1 on the cycle after reset; new instructions proceed normally.

Source files
------------

// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard Architecture Processor compare datapath:
// compare opcodes, sequencer states and the opcode-class helper.
package hap_pkg;

  localparam logic [4:0] OP_LT  = 5'b01011;
  localparam logic [4:0] OP_GT  = 5'b01100;
  localparam logic [4:0] OP_EQ  = 5'b01101;
  localparam logic [4:0] OP_GTE = 5'b01110;
  localparam logic [4:0] OP_LTE = 5'b01111;
  localparam logic [4:0] OP_NE  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic is_cmp_op(input logic [4:0] op);
    logic res;
    case (op)
      OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE: res = 1'b1;
      default:                                    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_eval.sv
// Combinational unsigned comparator for the six compare opcodes.
// Non-compare opcodes evaluate to 0.
module cmp_eval
  import hap_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              result
);

  always_comb begin
    result = 1'b0;
    case (opcode)
      OP_LT:   result = (a <  b);
      OP_GT:   result = (a >  b);
      OP_EQ:   result = (a == b);
      OP_GTE:  result = (a >= b);
      OP_LTE:  result = (a <= b);
      OP_NE:   result = (a != b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/compare_seq.sv
// Four-state sequencer (IDLE/READ/EXEC/WRITE) that reads two registers,
// compares them unsigned and writes the 0/1 result back to the register file.
module compare_seq
  import hap_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              flag,
  output logic              done,
  output logic              illegal
);

  state_e            state;
  logic [4:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic              cmp_res;

  assign instr_ready = (state == ST_IDLE);

  cmp_eval #(.DATA_W(DATA_W)) u_eval (
    .opcode (op_q),
    .a      (rf_rd1),
    .b      (rf_rd2),
    .result (cmp_res)
  );

  // The read addresses are loaded on the accept edge so they are already on
  // the register-file ports throughout READ; read data then lands in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 5'd0;
      rd_q    <= {ADDR_W{1'b0}};
      rf_ra1  <= {ADDR_W{1'b0}};
      rf_ra2  <= {ADDR_W{1'b0}};
      rf_we   <= 1'b0;
      rf_wa   <= {ADDR_W{1'b0}};
      rf_wd   <= {DATA_W{1'b0}};
      flag    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (is_cmp_op(opcode)) begin
              op_q   <= opcode;
              rd_q   <= rd_addr;
              rf_ra1 <= rs1_addr;
              rf_ra2 <= rs2_addr;
              state  <= ST_READ;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        // Operands are consumed here, so a write to rs1/rs2 in WRITE is harmless.
        ST_EXEC: begin
          rf_we <= 1'b1;
          rf_wa <= rd_q;
          rf_wd <= {{(DATA_W-1){1'b0}}, cmp_res};
          flag  <= cmp_res;
          done  <= 1'b1;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq with a behavioural one-cycle-latency register file.
module tb_compare_seq;

  localparam logic [4:0] OP_LT  = 5'b01011;
  localparam logic [4:0] OP_GT  = 5'b01100;
  localparam logic [4:0] OP_EQ  = 5'b01101;
  localparam logic [4:0] OP_GTE = 5'b01110;
  localparam logic [4:0] OP_LTE = 5'b01111;
  localparam logic [4:0] OP_NE  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic [2:0] rs1_addr, rs2_addr, rd_addr;
  logic [2:0] rf_ra1, rf_ra2;
  logic [2:0] rf_rd1, rf_rd2;
  logic       rf_we;
  logic [2:0] rf_wa;
  logic [2:0] rf_wd;
  logic       flag, done, illegal;

  logic [2:0] regs [8];
  logic       tb_we = 1'b0;
  logic [2:0] tb_wa = 3'd0;
  logic [2:0] tb_wd = 3'd0;

  int vectors = 0;
  int miscompares = 0;

  compare_seq #(.DATA_W(3), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rf_ra1      (rf_ra1),
    .rf_ra2      (rf_ra2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .flag        (flag),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Register file: DUT write port has priority over the bench preload port.
  always @(posedge clk) begin
    if (rf_we) regs[rf_wa] <= rf_wd;
    else if (tb_we) regs[tb_wa] <= tb_wd;
    rf_rd1 <= regs[rf_ra1];
    rf_rd2 <= regs[rf_ra2];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [2:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Entered at the negedge of the accept cycle; leaves at the negedge of cycle 4.
  task automatic run_cmp(input string tag, input logic [4:0] op, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] rd, input logic exp);
    instr_valid = 1'b1; opcode = op; rs1_addr = s1; rs2_addr = s2; rd_addr = rd;
    chk({tag, ".c0_ready"}, 8'(instr_ready), 8'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, ".c1_ra1"}, 8'(rf_ra1), 8'(s1));
    chk({tag, ".c1_ra2"}, 8'(rf_ra2), 8'(s2));
    chk({tag, ".c1_ready"}, 8'(instr_ready), 8'd0);
    chk({tag, ".c1_illegal"}, 8'(illegal), 8'd0);
    @(negedge clk);
    chk({tag, ".c2_we"}, 8'(rf_we), 8'd0);
    @(negedge clk);
    chk({tag, ".c3_we"}, 8'(rf_we), 8'd1);
    chk({tag, ".c3_wa"}, 8'(rf_wa), 8'(rd));
    chk({tag, ".c3_wd"}, 8'(rf_wd), 8'(exp));
    chk({tag, ".c3_flag"}, 8'(flag), 8'(exp));
    chk({tag, ".c3_done"}, 8'(done), 8'd1);
    @(negedge clk);
    chk({tag, ".c4_ready"}, 8'(instr_ready), 8'd1);
    chk({tag, ".c4_we"}, 8'(rf_we), 8'd0);
    chk({tag, ".c4_done"}, 8'(done), 8'd0);
  endtask

  logic [4:0] ops [6];
  logic [2:0] exp_tab [6];
  logic [2:0] p_s1 [3];
  logic [2:0] p_s2 [3];

  initial begin
    ops     = '{OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE};
    // bit j = expected result for operand pair j: (4,4), (7,0), (0,7)
    exp_tab = '{3'b100, 3'b010, 3'b001, 3'b011, 3'b101, 3'b110};
    p_s1    = '{3'd4, 3'd6, 3'd0};
    p_s2    = '{3'd4, 3'd0, 3'd6};

    rst = 1'b1; instr_valid = 1'b0; opcode = 5'd0;
    rs1_addr = 3'd0; rs2_addr = 3'd0; rd_addr = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 8'(instr_ready), 8'd1);
    chk("rst_we", 8'(rf_we), 8'd0);
    chk("rst_wa", 8'(rf_wa), 8'd0);
    chk("rst_wd", 8'(rf_wd), 8'd0);
    chk("rst_ra1", 8'(rf_ra1), 8'd0);
    chk("rst_ra2", 8'(rf_ra2), 8'd0);
    chk("rst_flag", 8'(flag), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_illegal", 8'(illegal), 8'd0);
    rst = 1'b0;
    @(negedge clk);

    poke(3'd0, 3'd0); poke(3'd2, 3'd3); poke(3'd5, 3'd6);
    poke(3'd4, 3'd4); poke(3'd6, 3'd7);

    run_cmp("lt_taken", OP_LT, 3'd2, 3'd5, 3'd7, 1'b1);
    chk("lt_taken.r7", 8'(regs[7]), 8'd1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) begin
        run_cmp($sformatf("op%0d_pair%0d", i, j), ops[i], p_s1[j], p_s2[j], 3'd7, exp_tab[i][j]);
      end
    end

    // flag is 1 here (NE 0,7); an illegal opcode must not disturb it
    instr_valid = 1'b1; opcode = 5'b00000; rs1_addr = 3'd4; rs2_addr = 3'd4; rd_addr = 3'd2;
    @(negedge clk);
    chk("illegal.pulse", 8'(illegal), 8'd1);
    chk("illegal.we", 8'(rf_we), 8'd0);
    chk("illegal.ready", 8'(instr_ready), 8'd1);
    chk("illegal.flag", 8'(flag), 8'd1);
    chk("illegal.ra2", 8'(rf_ra2), 8'd6);
    run_cmp("b2b_eq", OP_EQ, 3'd4, 3'd4, 3'd7, 1'b1);

    poke(3'd3, 3'd5); poke(3'd1, 3'd2);
    run_cmp("ovl_gt", OP_GT, 3'd3, 3'd1, 3'd3, 1'b1);
    chk("ovl_gt.r3", 8'(regs[3]), 8'd1);
    poke(3'd1, 3'd1);
    run_cmp("ovl_eq", OP_EQ, 3'd3, 3'd1, 3'd3, 1'b1);
    chk("ovl_eq.r3", 8'(regs[3]), 8'd1);

    // reset during EXEC: the pending write to r5 must be dropped
    instr_valid = 1'b1; opcode = OP_LT; rs1_addr = 3'd0; rs2_addr = 3'd6; rd_addr = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.we", 8'(rf_we), 8'd0);
    chk("midrst.flag", 8'(flag), 8'd0);
    chk("midrst.done", 8'(done), 8'd0);
    chk("midrst.ready", 8'(instr_ready), 8'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst.idle_we", 8'(rf_we), 8'd0);
    end
    chk("midrst.r5", 8'(regs[5]), 8'd6);
    run_cmp("post_rst_lt", OP_LT, 3'd0, 3'd6, 3'd5, 1'b1);
    chk("post_rst_lt.r5", 8'(regs[5]), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
